event_readout_ctrl: RTL and testbench
=====================================

# event_readout_ctrl

Sequencer for one scintillator-triggered drift-tube event. Synchronises the scintillator coincidence, opens the tube timing window, then scans the 32 tube clock-cycle registers through an external mux. Writes a framed event (header, 32 tagged data words, trailer) into the 16x1024 readout FIFO, then clears the tube bank and holds off before re-arming. It replaces hard-coded counter-driven FIFO writes with an FSM that respects FIFO space and backpressure.

## Interface
- DRIFT_WINDOW, 256: cycles `gate_en` stays high per event (range 2..4095).
- CLR_CYCLES, 12: cycles `tube_clr` stays high after readout (range 1..255).
- HOLDOFF, 16: idle cycles after clear before re-arming (range 0..255).
- FIFO_DEPTH, 1024: FIFO capacity in words; the event size is fixed at 34 words.

Ports:
- clk100  in  1  system 100 MHz clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- scin_coin  in  1  raw scintillator coincidence; asynchronous to clk100.
- ch_data  in  8  clock-cycle value of the tube addressed by `ch_sel` (combinational from the tube bank).
- fifo_full  in  1  FIFO full flag.
- fifo_wr_count  in  10  FIFO write-side word count.
- gate_en  out  1  tube timing window enable.
- tube_clr  out  1  clears all tube registers.
- ch_sel  out  5  tube index 0..31: 0-7 = 3A, 8-15 = 3B, 16-23 = 4A, 24-31 = 4B.
- fifo_din  out  16  FIFO write data.
- fifo_wr  out  1  FIFO write enable.
- busy  out  1  high in every state except IDLE.
- evt_cnt  out  8  count of accepted events; wraps.
- drop_cnt  out  8  count of events dropped for lack of space; saturates at 255.

## Operation
- `scin_coin` passes through a 2-flop synchroniser, followed by a registered rising-edge detect. Only a 0->1 transition seen in IDLE starts an event. Edges in any other state are ignored and not counted.
- States:
  - IDLE -> WINDOW on an edge.
  - WINDOW: `gate_en`=1 for DRIFT_WINDOW cycles, then -> CHECK.
  - CHECK: 1 cycle, `gate_en`=0.
    - If FIFO_DEPTH - `fifo_wr_count` >= 34: -> HEADER.
    - Otherwise: `drop_cnt`++ and -> CLEAR.
  - HEADER: write {8'hE0, evt_cnt}, then -> SCAN.
  - SCAN: for i = 0..31, write {ch_data, 3'b101, i[4:0]} while `ch_sel`=i, then -> TRAILER.
  - TRAILER: write 16'hFFFF; `evt_cnt`++ on acceptance; -> CLEAR.
  - CLEAR: `tube_clr`=1 for CLR_CYCLES cycles, then -> HOLDOFF.
  - HOLDOFF: wait HOLDOFF cycles (0 means skip), then -> IDLE.
- Write handshake:
  - `fifo_din` and `fifo_wr` are registered outputs.
  - A word is accepted on a rising edge where `fifo_wr`=1 and `fifo_full`=0.
  - If `fifo_full`=1, `fifo_din`, `fifo_wr` and `ch_sel` hold unchanged until the word is accepted. No word is ever dropped or duplicated.
- `ch_sel` is updated one cycle before the word using it is registered, so `ch_data` has one full cycle to settle.
- `ch_sel` = 0 outside SCAN. `fifo_din` = 16'hFFFF whenever `fifo_wr`=0.

## Timing
- Reset values: `gate_en`=0, `tube_clr`=0, `ch_sel`=0, `fifo_din`=16'hFFFF, `fifo_wr`=0, `busy`=0, `evt_cnt`=0, `drop_cnt`=0, synchroniser=0, state=IDLE.
- `scin_coin` first sampled high at edge N: `gate_en` rises after edge N+3 and stays high exactly DRIFT_WINDOW cycles.
- Without backpressure:
  - The header has `fifo_wr`=1 two cycles after `gate_en` falls.
  - 34 words follow on consecutive cycles.
  - `tube_clr` rises the cycle after the trailer is accepted.
- Each stall cycle adds exactly one cycle to the event.
- `busy` spans from the cycle `gate_en` rises through the last HOLDOFF cycle.
- Reset mid-event: the FSM aborts immediately. An already-accepted partial frame stays in the FIFO; the downstream reader resynchronises on the 0xE0 header byte.
- `scin_coin` still high on the return to IDLE does not retrigger; it must go low and then high again.
- `evt_cnt` wraps 255 -> 0. `drop_cnt` holds at 255.

## Test plan
- Single event, DRIFT_WINDOW=256, `ch_data` = index+1, `fifo_full`=0 -> 34 consecutive writes: 16'hE000, then 16'h01A0 .. 16'h20BF, then 16'hFFFF; `evt_cnt`=1; `tube_clr` high for 12 cycles.
- `fifo_full` forced high for 5 cycles while the word for channel 10 is presented -> `fifo_din`=16'h0BAA held for 6 cycles; no duplicate and no gap in the 34-word sequence; event 5 cycles longer.
- `fifo_wr_count`=991 at CHECK -> no writes; `drop_cnt`=1; `evt_cnt` unchanged; CLEAR and HOLDOFF still execute. With `fifo_wr_count`=990 -> full event written.
- Second `scin_coin` pulse during WINDOW and another during SCAN -> ignored; exactly one frame written; a pulse after `busy` falls starts event 2 with header 16'hE001.
- `rst` asserted mid-SCAN -> all outputs at reset values in the same cycle; the next `scin_coin` edge produces a complete frame with header 16'hE000.
- 256 back-to-back events -> header byte wraps to 16'hE000 on event 257. 300 forced drops -> `drop_cnt` stays at 255.

Source files
------------

// File: rtl/event_readout_ctrl.sv
// Event sequencer for the scintillator-triggered drift-tube readout: opens the tube
// timing window, scans the 32 tube registers through the external mux and frames them into the FIFO.
module event_readout_ctrl #(
    parameter int DRIFT_WINDOW = 256,
    parameter int CLR_CYCLES   = 12,
    parameter int HOLDOFF      = 16,
    parameter int FIFO_DEPTH   = 1024
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        scin_coin,
    input  logic [7:0]  ch_data,
    input  logic        fifo_full,
    input  logic [9:0]  fifo_wr_count,
    output logic        gate_en,
    output logic        tube_clr,
    output logic [4:0]  ch_sel,
    output logic [15:0] fifo_din,
    output logic        fifo_wr,
    output logic        busy,
    output logic [7:0]  evt_cnt,
    output logic [7:0]  drop_cnt
);

    localparam int EVT_WORDS = 34;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WINDOW,
        S_CHECK,
        S_HEADER,
        S_SCAN,
        S_TRAILER,
        S_CLEAR,
        S_HOLDOFF
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] cnt;
    logic [11:0] cnt_nxt;
    logic [4:0]  idx;
    logic [4:0]  idx_nxt;
    logic        trl_loaded;
    logic        trl_loaded_nxt;

    logic        coin_s1;
    logic        coin_s2;
    logic        coin_s2_d;
    logic        coin_edge;

    logic        load;
    logic [15:0] load_word;
    logic        evt_inc;
    logic        drop_inc;
    logic        accept;
    logic        can_load;
    logic [11:0] space;
    logic        space_ok;

    // FIFO handshake: fifo_wr is the valid and ~fifo_full the ready; a word moves on a
    // rising edge with both high. The output register may only be reloaded when it is
    // empty or its current word moves on that same edge, so nothing is dropped or repeated.
    assign accept   = fifo_wr & ~fifo_full;
    assign can_load = ~fifo_wr | ~fifo_full;

    assign space    = 12'(FIFO_DEPTH) - {2'b00, fifo_wr_count};
    assign space_ok = (space >= 12'(EVT_WORDS));

    assign gate_en  = (state == S_WINDOW);
    assign tube_clr = (state == S_CLEAR);
    assign busy     = (state != S_IDLE);
    // The mux address leads the registered word by one cycle so ch_data can settle.
    assign ch_sel   = (state == S_SCAN) ? idx : 5'd0;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            coin_s1   <= 1'b0;
            coin_s2   <= 1'b0;
            coin_s2_d <= 1'b0;
            coin_edge <= 1'b0;
        end else begin
            coin_s1   <= scin_coin;
            coin_s2   <= coin_s1;
            coin_s2_d <= coin_s2;
            coin_edge <= coin_s2 & ~coin_s2_d;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 12'd0;
            idx        <= 5'd0;
            trl_loaded <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            trl_loaded <= trl_loaded_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        trl_loaded_nxt = trl_loaded;
        load           = 1'b0;
        load_word      = 16'hFFFF;
        evt_inc        = 1'b0;
        drop_inc       = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = 12'd0;
                if (coin_edge) begin
                    state_nxt = S_WINDOW;
                end
            end
            S_WINDOW: begin
                if (cnt == 12'(DRIFT_WINDOW - 1)) begin
                    cnt_nxt   = 12'd0;
                    state_nxt = S_CHECK;
                end else begin
                    cnt_nxt = cnt + 12'd1;
                end
            end
            S_CHECK: begin
                if (space_ok) begin
                    state_nxt = S_HEADER;
                end else begin
                    drop_inc  = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_HEADER: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = {8'hE0, evt_cnt};
                    idx_nxt   = 5'd0;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = {ch_data, 3'b101, idx};
                    if (idx == 5'd31) begin
                        idx_nxt        = 5'd0;
                        trl_loaded_nxt = 1'b0;
                        state_nxt      = S_TRAILER;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            S_TRAILER: begin
                // First load the trailer, then stay until it has actually left the register.
                if (!trl_loaded) begin
                    if (can_load) begin
                        load           = 1'b1;
                        load_word      = 16'hFFFF;
                        trl_loaded_nxt = 1'b1;
                    end
                end else if (accept) begin
                    evt_inc        = 1'b1;
                    trl_loaded_nxt = 1'b0;
                    cnt_nxt        = 12'd0;
                    state_nxt      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt == 12'(CLR_CYCLES - 1)) begin
                    cnt_nxt   = 12'd0;
                    state_nxt = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                end else begin
                    cnt_nxt = cnt + 12'd1;
                end
            end
            S_HOLDOFF: begin
                if (cnt == 12'(HOLDOFF - 1)) begin
                    cnt_nxt   = 12'd0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 12'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            fifo_wr  <= 1'b0;
            fifo_din <= 16'hFFFF;
        end else if (load) begin
            fifo_wr  <= 1'b1;
            fifo_din <= load_word;
        end else if (accept) begin
            fifo_wr  <= 1'b0;
            fifo_din <= 16'hFFFF;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            evt_cnt  <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (evt_inc) begin
                evt_cnt <= evt_cnt + 8'd1;
            end
            if (drop_inc && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_event_readout_ctrl.sv
// Bench for event_readout_ctrl: directed events with a word scoreboard on the FIFO port,
// plus a short-window instance for counter wrap and saturation.
module tb_event_readout_ctrl;

    logic        clk100 = 1'b0;
    logic        rst;
    logic        scin_coin;
    logic [7:0]  ch_data;
    logic        fifo_full;
    logic [9:0]  fifo_wr_count;
    logic        gate_en;
    logic        tube_clr;
    logic [4:0]  ch_sel;
    logic [15:0] fifo_din;
    logic        fifo_wr;
    logic        busy;
    logic [7:0]  evt_cnt;
    logic [7:0]  drop_cnt;

    logic        f_coin;
    logic [9:0]  f_wr_count;
    logic        f_gate_en;
    logic        f_tube_clr;
    logic [4:0]  f_ch_sel;
    logic [15:0] f_fifo_din;
    logic        f_fifo_wr;
    logic        f_busy;
    logic [7:0]  f_evt_cnt;
    logic [7:0]  f_drop_cnt;
    logic [15:0] f_last_hdr;

    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk100 = ~clk100;

    // tube bank model: each tube reads back its index plus one
    assign ch_data = 8'(ch_sel) + 8'd1;

    event_readout_ctrl u_dut (
        .clk100        (clk100),
        .rst           (rst),
        .scin_coin     (scin_coin),
        .ch_data       (ch_data),
        .fifo_full     (fifo_full),
        .fifo_wr_count (fifo_wr_count),
        .gate_en       (gate_en),
        .tube_clr      (tube_clr),
        .ch_sel        (ch_sel),
        .fifo_din      (fifo_din),
        .fifo_wr       (fifo_wr),
        .busy          (busy),
        .evt_cnt       (evt_cnt),
        .drop_cnt      (drop_cnt)
    );

    event_readout_ctrl #(
        .DRIFT_WINDOW (2),
        .CLR_CYCLES   (1),
        .HOLDOFF      (0),
        .FIFO_DEPTH   (1024)
    ) u_fast (
        .clk100        (clk100),
        .rst           (rst),
        .scin_coin     (f_coin),
        .ch_data       (8'h00),
        .fifo_full     (1'b0),
        .fifo_wr_count (f_wr_count),
        .gate_en       (f_gate_en),
        .tube_clr      (f_tube_clr),
        .ch_sel        (f_ch_sel),
        .fifo_din      (f_fifo_din),
        .fifo_wr       (f_fifo_wr),
        .busy          (f_busy),
        .evt_cnt       (f_evt_cnt),
        .drop_cnt      (f_drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] frame_word(input int i);
        logic [7:0] d;
        logic [4:0] ix;
        d  = 8'(i + 1);
        ix = 5'(i);
        return {d, 3'b101, ix};
    endfunction

    task automatic push_frame(input logic [7:0] evt);
        exp_q.push_back({8'hE0, evt});
        for (int i = 0; i < 32; i++) exp_q.push_back(frame_word(i));
        exp_q.push_back(16'hFFFF);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gate_en"},  gate_en,  0);
        check({tag, "_tube_clr"}, tube_clr, 0);
        check({tag, "_ch_sel"},   ch_sel,   0);
        check({tag, "_fifo_din"}, fifo_din, 16'hFFFF);
        check({tag, "_fifo_wr"},  fifo_wr,  0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_evt_cnt"},  evt_cnt,  0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic idle_gap();
        repeat (5) @(posedge clk100);
    endtask

    // Starts one event and checks its timeline; exp_span is the fifo_wr-high length.
    task automatic track_event(input int exp_span, input bit dropped);
        int n;
        @(posedge clk100);
        #1 scin_coin = 1'b1;
        n = 0;
        while (gate_en !== 1'b1 && n < 20) begin @(negedge clk100); n++; end
        check("gate_rise_latency", n, 5);
        scin_coin = 1'b0;
        n = 0;
        while (gate_en === 1'b1 && n < 5000) begin n++; @(negedge clk100); end
        check("gate_width", n, 256);
        if (!dropped) begin
            n = 0;
            while (fifo_wr !== 1'b1 && n < 10) begin @(negedge clk100); n++; end
            check("header_delay", n, 2);
            n = 0;
            while (fifo_wr === 1'b1 && n < 200) begin n++; @(negedge clk100); end
            check("write_span", n, exp_span);
            check("clr_after_trailer", tube_clr, 1);
        end else begin
            @(negedge clk100);
            check("drop_to_clear", {fifo_wr, tube_clr}, 2'b01);
        end
        n = 0;
        while (tube_clr === 1'b1 && n < 300) begin n++; @(negedge clk100); end
        check("clr_width", n, 12);
        n = 0;
        while (busy === 1'b1 && n < 300) begin n++; @(negedge clk100); end
        check("holdoff_len", n, 16);
    endtask

    task automatic stall_ch10();
        int n;
        int held;
        n = 0;
        while (ch_sel !== 5'd10 && n < 600) begin @(negedge clk100); n++; end
        check("stall_reach_ch10", ch_sel, 10);
        @(posedge clk100);
        #1 fifo_full = 1'b1;
        held = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk100);
            if (fifo_wr && fifo_din == 16'h0BAA && ch_sel == 5'd11) held++;
            @(posedge clk100);
        end
        #1 fifo_full = 1'b0;
        @(negedge clk100);
        if (fifo_wr && fifo_din == 16'h0BAA && ch_sel == 5'd11) held++;
        check("stall_hold_cycles", held, 6);
        @(negedge clk100);
        check("after_stall_word", fifo_din, frame_word(11));
    endtask

    task automatic extra_pulses();
        int n;
        n = 0;
        while (gate_en !== 1'b1 && n < 20) begin @(negedge clk100); n++; end
        repeat (50) @(negedge clk100);
        scin_coin = 1'b1;
        repeat (3) @(negedge clk100);
        scin_coin = 1'b0;
        n = 0;
        while (ch_sel !== 5'd5 && n < 600) begin @(negedge clk100); n++; end
        scin_coin = 1'b1;
        repeat (3) @(negedge clk100);
        scin_coin = 1'b0;
    endtask

    task automatic fast_event();
        int n;
        @(posedge clk100);
        #1 f_coin = 1'b1;
        n = 0;
        while (f_busy !== 1'b1 && n < 20) begin @(negedge clk100); n++; end
        f_coin = 1'b0;
        while (f_busy === 1'b1 && n < 300) begin @(negedge clk100); n++; end
        if (n >= 300) check("fast_event_timeout", n, 0);
    endtask

    // scoreboard monitor: every accepted word must be the next expected one
    always @(negedge clk100) begin
        if (!rst) begin
            if (fifo_wr && !fifo_full) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %0h, expected no write", fifo_din);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("fifo_word", fifo_din, exp_w);
                end
            end
            if (!fifo_wr) check("idle_din", fifo_din, 16'hFFFF);
        end
    end

    always @(negedge clk100) begin
        if (!rst && f_fifo_wr && f_fifo_din[15:8] == 8'hE0) f_last_hdr = f_fifo_din;
    end

    initial begin
        #800000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        scin_coin = 1'b0;
        fifo_full = 1'b0;
        fifo_wr_count = 10'd0;
        f_coin = 1'b0;
        f_wr_count = 10'd0;
        f_last_hdr = 16'h0000;
        repeat (3) @(posedge clk100);
        #1 check_reset("reset");
        rst = 1'b0;
        idle_gap();

        push_frame(8'h00);
        track_event(34, 1'b0);
        check("a_evt_cnt", evt_cnt, 1);
        check("a_drop_cnt", drop_cnt, 0);
        idle_gap();

        push_frame(8'h01);
        fork
            track_event(39, 1'b0);
            stall_ch10();
        join
        check("b_evt_cnt", evt_cnt, 2);
        idle_gap();

        fifo_wr_count = 10'd991;
        track_event(0, 1'b1);
        check("c_drop_cnt", drop_cnt, 1);
        check("c_evt_cnt", evt_cnt, 2);
        idle_gap();

        fifo_wr_count = 10'd990;
        push_frame(8'h02);
        track_event(34, 1'b0);
        check("d_evt_cnt", evt_cnt, 3);
        check("d_drop_cnt", drop_cnt, 1);
        fifo_wr_count = 10'd0;
        idle_gap();

        push_frame(8'h03);
        fork
            track_event(34, 1'b0);
            extra_pulses();
        join
        repeat (20) @(negedge clk100);
        check("no_retrigger_busy", busy, 0);
        check("e_evt_cnt", evt_cnt, 4);
        push_frame(8'h04);
        track_event(34, 1'b0);
        check("f_evt_cnt", evt_cnt, 5);
        idle_gap();

        push_frame(8'h05);
        @(posedge clk100);
        #1 scin_coin = 1'b1;
        n = 0;
        while (ch_sel !== 5'd8 && n < 600) begin
            @(negedge clk100);
            if (gate_en) scin_coin = 1'b0;
            n++;
        end
        check("scan_reach_ch8", ch_sel, 8);
        @(posedge clk100);
        #1 rst = 1'b1;
        #1 check_reset("midscan");
        exp_q.delete();
        @(posedge clk100);
        #1 rst = 1'b0;
        idle_gap();
        push_frame(8'h00);
        track_event(34, 1'b0);
        check("h_evt_cnt", evt_cnt, 1);
        idle_gap();

        for (int e = 0; e < 256; e++) fast_event();
        check("wrap_hdr_256", f_last_hdr, 16'hE0FF);
        check("wrap_evt_cnt_256", f_evt_cnt, 0);
        fast_event();
        check("wrap_hdr_257", f_last_hdr, 16'hE000);
        check("wrap_evt_cnt_257", f_evt_cnt, 1);

        f_wr_count = 10'd1000;
        for (int e = 0; e < 254; e++) fast_event();
        check("drop_cnt_254", f_drop_cnt, 254);
        for (int e = 0; e < 46; e++) fast_event();
        check("drop_cnt_sat", f_drop_cnt, 255);
        check("drop_evt_cnt", f_evt_cnt, 1);

        repeat (10) @(negedge clk100);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
